fft_reorder_sched: RTL
======================

# fft_reorder_sched

Scheduler for the two-bank bit-reversal reorder buffer at the output of the 32-point MDC FFT. It accepts stage-5 output pairs (two samples per cycle) and drives write enable, bank select and write address. It drains each completed bank one sample per cycle in bit-reversed order under a valid/ready handshake toward the downstream consumer. It tracks ownership of both banks, stalls the upstream stage when neither bank is free, and flags lost pairs.

## Interface
- N, 32, points per frame (power of two)
- LOG2N, 5, log2(N); width of the sample address
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  stage-5 pair (upper, lower) present this cycle
- in_ready  out  1  target bank can accept a pair
- wr_en  out  1  write strobe for the pair; equals in_valid & in_ready
- wr_bank  out  1  bank written (0 = A, 1 = B)
- wr_addr  out  LOG2N  even address; upper sample goes to wr_addr, lower to wr_addr+1
- rd_bank  out  1  bank read
- rd_addr  out  LOG2N  bit-reversed read address; buffer memory is read combinationally
- out_valid  out  1  sample at rd_bank/rd_addr is valid
- out_ready  in  1  consumer accepts the sample
- out_first  out  1  out_valid and read count == 0
- out_last  out  1  out_valid and read count == N-1
- frame_done  out  1  one-cycle pulse, registered, after the last sample handshake
- bank_full  out  2  bit i set while bank i is FULL or DRAINING
- overflow  out  1  sticky: a pair was offered while in_ready = 0
- clear_err  in  1  clears overflow

## Operation
- Each bank has a state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY. All banks are EMPTY at reset.
- Write pointer wsel (reset 0):
  - in_ready = (state[wsel] is EMPTY or FILLING).
  - On each write, wr_cnt (0..N/2-1) increments, wr_addr = 2*wr_cnt, and state[wsel] = FILLING.
  - On the write with wr_cnt = N/2-1: state[wsel] -> FULL, wr_cnt -> 0, wsel toggles.
- Read pointer rsel (reset 0):
  - In DRAINING, out_valid = 1 and rd_addr = bitrev(rd_cnt).
  - When state[rsel] = FULL, it moves to DRAINING on the next edge.
  - rd_cnt (0..N-1) advances only on out_valid & out_ready.
  - On the handshake with rd_cnt = N-1: state[rsel] -> EMPTY, rsel toggles, rd_cnt -> 0, frame_done pulses next cycle.
- Stalls:
  - While out_ready = 0, rd_addr holds and out_valid stays high (AXI-style: valid never drops without a handshake).
  - While the consumer stalls, the write side keeps filling the other bank if it is EMPTY.
- Simultaneous events:
  - Write completion on one bank and read completion on the other in the same cycle both take effect.
  - A bank released to EMPTY is writable on the next cycle, not the same cycle.
- Overflow:
  - in_valid & !in_ready sets overflow; the pair is dropped and no write occurs.
  - If clear_err and a set condition occur in the same cycle, the set wins.
- Reset mid-frame:
  - All counters, pointers, states and flags clear immediately.
  - Partial bank contents are abandoned; no frame_done is issued.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_first = 0, out_last = 0, frame_done = 0, wr_en = 0 (in_valid = 0 during reset), wr_bank = 0, wr_addr = 0, rd_bank = 0, rd_addr = 0, bank_full = 2'b00, overflow = 0.
- in_ready, wr_en and wr_addr are combinational from registered state and in_valid; no dependency on out_ready.
- Fill-to-drain latency: if the last pair is written at cycle T and the read side is idle, the bank is FULL at T+1 and DRAINING at T+2, so out_valid first rises at T+2 with rd_addr = 0.
- Throughput:
  - The write side fills a bank in N/2 cycles; the read side drains it in N cycles.
  - With continuous in_valid, in_ready deasserts for N/2 cycles per frame in steady state.
  - Output is gapless across frames when out_ready = 1: the next bank is already FULL when the current drain completes, and it enters DRAINING on the same edge that the current bank goes EMPTY.
- Bit-reversed order for N = 32 begins 0, 16, 8, 24, 4, 20, 12, 28, 2, … and ends at 31.

## Test plan
- Single frame, out_ready = 1, pairs at cycles 0–15 -> wr_addr 0, 2, …, 30 on bank 0; out_valid from cycle 17 to 48; rd_addr sequence 0, 16, 8, 24, …, 31; out_first at cycle 17, out_last at cycle 48, frame_done at cycle 49.
- Continuous in_valid for 3 frames -> bank 1 filled in cycles 16–31; in_ready low from cycle 32 until bank 0 is released (high at cycle 50); out_valid continuous from cycle 17 through 112; no overflow.
- out_ready low for 5 cycles mid-drain at rd_cnt = 7 -> rd_addr holds 28 and out_valid stays 1; the sequence resumes with no skipped or duplicated addresses; total drain takes 37 cycles.
- in_valid asserted while both banks are full -> no wr_en; overflow sets; clear_err in a later idle cycle clears it; clear_err together with a new violation leaves overflow = 1.
- rst_n low at write pair 9 of frame 2 while frame 1 is draining -> all outputs return to reset values; a following frame starts at bank 0, wr_addr 0.
- Bank 1 write completion and bank 0 read completion in the same cycle -> both states update; bank_full goes 01 -> 10; frame_done pulses; no lost pair.

Source files
------------

// File: rtl/fft_reorder_sched.sv
// Two-bank bit-reversal reorder scheduler for the 32-point MDC FFT output.
// Writes arrive in stage-5 pairs; each completed bank drains in bit-reversed order under valid/ready.
module fft_reorder_sched #(
    parameter int N     = 32,
    parameter int LOG2N = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic             wr_bank,
    output logic [LOG2N-1:0] wr_addr,
    output logic             rd_bank,
    output logic [LOG2N-1:0] rd_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             out_last,
    output logic             frame_done,
    output logic [1:0]       bank_full,
    output logic             overflow,
    input  logic             clear_err
);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

    localparam int               WC_W    = LOG2N - 1;
    localparam logic [WC_W-1:0]  WR_LAST = WC_W'(N / 2 - 1);
    localparam logic [LOG2N-1:0] RD_LAST = LOG2N'(N - 1);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    bank_state_e      state_q [2];
    bank_state_e      state_d [2];
    logic             wsel_q, wsel_d;
    logic             rsel_q, rsel_d;
    logic [WC_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;
    logic             rel_block;
    logic             rd_hs;

    // The bank released on the previous edge is still held off for one cycle.
    assign rel_block = frame_done_q && (wsel_q != rsel_q);
    assign in_ready  = (state_q[wsel_q] == FILLING) ||
                       ((state_q[wsel_q] == EMPTY) && !rel_block);
    assign wr_en     = in_valid && in_ready;
    assign wr_bank   = wsel_q;
    assign wr_addr   = {wr_cnt_q, 1'b0};

    assign out_valid  = (state_q[rsel_q] == DRAINING);
    assign rd_bank    = rsel_q;
    assign rd_addr    = bitrev(rd_cnt_q);
    assign out_first  = out_valid && (rd_cnt_q == '0);
    assign out_last   = out_valid && (rd_cnt_q == RD_LAST);
    assign rd_hs      = out_valid && out_ready;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign bank_full[0] = (state_q[0] == FULL) || (state_q[0] == DRAINING);
    assign bank_full[1] = (state_q[1] == FULL) || (state_q[1] == DRAINING);

    always_comb begin
        state_d      = state_q;
        wsel_d       = wsel_q;
        rsel_d       = rsel_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;

        if (state_q[rsel_q] == FULL) state_d[rsel_q] = DRAINING;

        if (rd_hs) begin
            if (rd_cnt_q == RD_LAST) begin
                state_d[rsel_q] = EMPTY;
                rsel_d          = ~rsel_q;
                rd_cnt_d        = '0;
                frame_done_d    = 1'b1;
                // Hand over to an already-full bank on the same edge for gapless output.
                if (state_q[~rsel_q] == FULL) state_d[~rsel_q] = DRAINING;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end

        if (wr_en) begin
            if (wr_cnt_q == WR_LAST) begin
                state_d[wsel_q] = FULL;
                wr_cnt_d        = '0;
                wsel_d          = ~wsel_q;
            end else begin
                state_d[wsel_q] = FILLING;
                wr_cnt_d        = wr_cnt_q + 1'b1;
            end
        end

        if (in_valid && !in_ready) overflow_d = 1'b1;
        else if (clear_err)        overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0]   <= EMPTY;
            state_q[1]   <= EMPTY;
            wsel_q       <= 1'b0;
            rsel_q       <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wsel_q       <= wsel_d;
            rsel_q       <= rsel_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule
